seed_reseed_ctrl: RTL

- Sits directly downstream of the ADC seed generator. Consumes its two 128-bit seeds every cycle.
- Runs a repetition health test on the seeds and folds several samples into one 256-bit seed.
- Delivers that seed to the PRNG core over a valid/ready handshake.
- Produces one seed automatically after reset, then one more per reseed request.

---
 rtl/prng_seed_pkg.sv | 32 +++
 rtl/seed_health_mon.sv | 37 +++
 rtl/seed_reseed_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prng_seed_pkg.sv
// Shared types and constants for the seed reseed controller and its health monitor.
package prng_seed_pkg;

  localparam int unsigned SEED_W     = 256;
  localparam int unsigned HALF_W     = 128;
  localparam int unsigned WHITEN_SHR = 7;
  localparam int unsigned WHITEN_SHL = 11;

  typedef enum logic [2:0] {
    ST_WARMUP,
    ST_COLLECT,
    ST_FINAL,
    ST_HOLD,
    ST_IDLE,
    ST_FAIL
  } state_e;

  // One upstream sample: seed1 forms the high half, seed2 the low half.
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
  } sample_t;

  function automatic logic [SEED_W-1:0] rotl1(input logic [SEED_W-1:0] v);
    return {v[SEED_W-2:0], v[SEED_W-1]};
  endfunction

  function automatic logic [SEED_W-1:0] whiten(input logic [SEED_W-1:0] v);
    return v ^ (v >> WHITEN_SHR) ^ (v << WHITEN_SHL);
  endfunction

endpackage

// File: rtl/seed_health_mon.sv
// Repetition health test: pulses fail_c on the cycle the REP_LIMIT-th
// consecutive identical sample comparison is seen.
module seed_health_mon
  import prng_seed_pkg::*;
#(
  parameter int unsigned REP_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SEED_W-1:0] sample,
  output logic              fail_c
);

  localparam int unsigned CNT_W = $clog2(REP_LIMIT + 1);

  logic [SEED_W-1:0] prev;
  logic              prev_valid;
  logic [CNT_W-1:0]  rep_cnt;
  logic              repeat_c;

  assign repeat_c = prev_valid && (sample == prev);
  assign fail_c   = en && repeat_c && (rep_cnt == CNT_W'(REP_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      rep_cnt    <= '0;
    end else if (en) begin
      prev       <= sample;
      prev_valid <= 1'b1;
      rep_cnt    <= repeat_c ? rep_cnt + CNT_W'(1) : '0;
    end
  end

endmodule

// File: rtl/seed_reseed_ctrl.sv
// Folds upstream ADC samples into 256-bit seeds for the PRNG core, gated by a
// repetition health test. Define SEED_WHITEN_EN to add a whitening FINAL stage.
module seed_reseed_ctrl
  import prng_seed_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned ACCUM_SAMPLES = 4,
  parameter int unsigned REP_LIMIT     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] seed1,
  input  logic [HALF_W-1:0] seed2,
  input  logic              reseed_req,
  input  logic              seed_ready,
  output logic [SEED_W-1:0] seed_out,
  output logic              seed_valid,
  output logic              busy,
  output logic              health_fail
);

  localparam int unsigned CNT_MAX = (WARMUP_CYCLES > ACCUM_SAMPLES) ? WARMUP_CYCLES : ACCUM_SAMPLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SEED_W-1:0] acc, acc_nxt;
  logic              pending, pending_nxt;
  logic [SEED_W-1:0] seed_out_nxt;
  logic              seed_valid_nxt, busy_nxt, health_fail_nxt;
  logic              enter_collect;
  logic              fail_c;
  sample_t           smp;
  logic [SEED_W-1:0] acc_fold;

  assign smp      = '{hi: seed1, lo: seed2};
  assign acc_fold = rotl1(acc) ^ SEED_W'(smp);

`ifdef SEED_WHITEN_EN
  logic [SEED_W-1:0] acc_white;
  assign acc_white = whiten(acc);
`endif

  seed_health_mon #(
    .REP_LIMIT(REP_LIMIT)
  ) u_health (
    .clk   (clk),
    .rst   (rst),
    .en    (state != ST_FAIL),
    .sample(SEED_W'(smp)),
    .fail_c(fail_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    acc_nxt         = acc;
    pending_nxt     = pending | (reseed_req && !(state inside {ST_IDLE, ST_FAIL}));
    seed_out_nxt    = seed_out;
    health_fail_nxt = health_fail;
    enter_collect   = 1'b0;

    case (state)
      ST_WARMUP: begin
        if (cnt == CNT_W'(WARMUP_CYCLES - 1)) enter_collect = 1'b1;
        else                                  cnt_nxt = cnt + CNT_W'(1);
      end
      ST_COLLECT: begin
        acc_nxt = acc_fold;
        if (cnt == CNT_W'(ACCUM_SAMPLES - 1)) begin
          cnt_nxt = '0;
`ifdef SEED_WHITEN_EN
          state_nxt = ST_FINAL;
`else
          // An all-zero fold is never handed out; start a fresh accumulation.
          if (acc_fold == '0) begin
            enter_collect = 1'b1;
          end else begin
            seed_out_nxt = acc_fold;
            state_nxt    = ST_HOLD;
          end
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`ifdef SEED_WHITEN_EN
      ST_FINAL: begin
        if (acc_white == '0) begin
          enter_collect = 1'b1;
        end else begin
          seed_out_nxt = acc_white;
          state_nxt    = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        // A request arriving on the transfer cycle itself is not dropped.
        if (seed_ready) begin
          if (pending || reseed_req) enter_collect = 1'b1;
          else                       state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (reseed_req) enter_collect = 1'b1;
      end
      default: ;
    endcase

    if (enter_collect) begin
      state_nxt   = ST_COLLECT;
      acc_nxt     = '0;
      cnt_nxt     = '0;
      pending_nxt = 1'b0;
    end

    if (fail_c) begin
      state_nxt       = ST_FAIL;
      health_fail_nxt = 1'b1;
    end

    seed_valid_nxt = (state_nxt == ST_HOLD);
    busy_nxt       = state_nxt inside {ST_WARMUP, ST_COLLECT, ST_FINAL};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_WARMUP;
      cnt         <= '0;
      acc         <= '0;
      pending     <= 1'b0;
      seed_out    <= '0;
      seed_valid  <= 1'b0;
      busy        <= 1'b1;
      health_fail <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      pending     <= pending_nxt;
      seed_out    <= seed_out_nxt;
      seed_valid  <= seed_valid_nxt;
      busy        <= busy_nxt;
      health_fail <= health_fail_nxt;
    end
  end

endmodule
